// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for param_sync_fifo.
//   DEF_DEPTH / DEF_AF / DEF_AE : default depth and almost-full/empty levels
//   addr_w()                    : address width (log2 of depth) for the storage
package fifo_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_AF    = DEF_DEPTH - 2;
  localparam int DEF_AE    = 2;

  // Index width for a power-of-two depth. The floor of 1 keeps slices legal
  // even if someone asks for a degenerate depth.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array with one synchronous write port and
// one asynchronous read port. The contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from raddr)
module fifo_mem #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with full/empty, almost-full/empty
// thresholds, occupancy count and sticky overflow/underflow flags.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output;
// otherwise dOut is registered with a one-cycle read latency.
//   CLK, RST        : clock, asynchronous active-high reset
//   wEN, dIn        : write request and data
//   rEN, rRDY       : read request, consumer ready (both needed to pop)
//   dOut, dValid    : read data and its valid flag
//   bFull, bEmpty   : buffer full / empty
//   bAlmostFull/Empty : count >= AF_LEVEL / count <= AE_LEVEL
//   count           : occupancy 0..DEPTH
//   ovf, unf, clrErr: sticky overflow/underflow and their synchronous clear
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      wEN,
  input  logic [WIDTH-1:0]          dIn,
  input  logic                      rEN,
  input  logic                      rRDY,
  output logic [WIDTH-1:0]          dOut,
  output logic                      dValid,
  output logic                      bFull,
  output logic                      bEmpty,
  output logic                      bAlmostFull,
  output logic                      bAlmostEmpty,
  output logic [addr_w(DEPTH):0]    count,
  output logic                      ovf,
  output logic                      unf,
  input  logic                      clrErr
);

  localparam int AW = addr_w(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable;
  // they wrap naturally modulo 2*DEPTH.
  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] rdata;
  logic             rd_req, wr_ok, rd_ok;

  assign bEmpty = (wptr == rptr);
  assign bFull  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count  = wptr - rptr;

  assign bAlmostFull  = (count >= (AW+1)'(AF_LEVEL));
  assign bAlmostEmpty = (count <= (AW+1)'(AE_LEVEL));

  // A read is only a request when the consumer is ready; rEN alone does
  // nothing, including not flagging underflow.
  assign rd_req = rEN & rRDY;
  assign wr_ok  = wEN & ~bFull;
  assign rd_ok  = rd_req & ~bEmpty;

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (CLK),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (dIn),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  // Sticky errors; a new error in the same cycle as clrErr takes priority.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wEN & bFull)        ovf <= 1'b1;
      else if (clrErr)        ovf <= 1'b0;
      if (rd_req & bEmpty)    unf <= 1'b1;
      else if (clrErr)        unf <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always presented; a pop just advances rptr.
  assign dOut   = rdata;
  assign dValid = ~bEmpty;
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dOut   <= '0;
      dValid <= 1'b0;
    end else begin
      dValid <= rd_ok;
      if (rd_ok) dOut <= rdata;
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed scoreboard bench for param_sync_fifo
// (WIDTH=8, DEPTH=8). Honours FIFO_FWFT_EN when defined.
module tb_param_sync_fifo;

  localparam int W = 8;
  localparam int D = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         wEN, rEN, rRDY, clrErr;
  logic [W-1:0] dIn;
  logic [W-1:0] dOut;
  logic         dValid, bFull, bEmpty, bAlmostFull, bAlmostEmpty, ovf, unf;
  logic [3:0]   count;

  param_sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .wEN(wEN), .dIn(dIn), .rEN(rEN), .rRDY(rRDY),
    .dOut(dOut), .dValid(dValid), .bFull(bFull), .bEmpty(bEmpty),
    .bAlmostFull(bAlmostFull), .bAlmostEmpty(bAlmostEmpty), .count(count),
    .ovf(ovf), .unf(unf), .clrErr(clrErr)
  );

  always #5 CLK = ~CLK;

  int           pass_cnt = 0;
  int           fail_cnt = 0;
  int           total    = 0;
  logic [W-1:0] sb[$];
  int           mcount;
  bit           movf, munf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict acceptance from the model, clock the DUT, then check.
  task automatic cyc();
    bit           wacc, racc;
    logic [W-1:0] wd, exp;
    wacc = wEN && (mcount < D);
    racc = rEN && rRDY && (mcount > 0);
    wd   = dIn;
    if (wEN && mcount == D) movf = 1'b1;
    else if (clrErr)        movf = 1'b0;
    if (rEN && rRDY && mcount == 0) munf = 1'b1;
    else if (clrErr)                munf = 1'b0;
    @(posedge CLK);
    #1;
    if (racc) begin
      exp = sb.pop_front();
`ifndef FIFO_FWFT_EN
      chk("dvalid_pop", 32'(dValid), 32'd1);
      chk("dout_pop", 32'(dOut), 32'(exp));
`endif
    end
`ifndef FIFO_FWFT_EN
    else chk("dvalid_idle", 32'(dValid), 32'd0);
`endif
    if (wacc) sb.push_back(wd);
    mcount = mcount + int'(wacc) - int'(racc);
`ifdef FIFO_FWFT_EN
    chk("fwft_dvalid", 32'(dValid), 32'(mcount > 0));
    if (mcount > 0) chk("fwft_dout", 32'(dOut), 32'(sb[0]));
`endif
    chk("count", 32'(count), 32'(mcount));
    chk("bfull", 32'(bFull), 32'(mcount == D));
    chk("bempty", 32'(bEmpty), 32'(mcount == 0));
    chk("bafull", 32'(bAlmostFull), 32'(mcount >= D - 2));
    chk("baempty", 32'(bAlmostEmpty), 32'(mcount <= 2));
    chk("ovf", 32'(ovf), 32'(movf));
    chk("unf", 32'(unf), 32'(munf));
  endtask

  initial begin
    RST = 1'b1; wEN = 0; rEN = 0; rRDY = 0; clrErr = 0; dIn = '0;
    mcount = 0; movf = 0; munf = 0;
    #12 RST = 1'b0;

    // reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(bEmpty), 32'd1);
    chk("rst_full", 32'(bFull), 32'd0);
    chk("rst_ae", 32'(bAlmostEmpty), 32'd1);
    chk("rst_af", 32'(bAlmostFull), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("rst_dvalid", 32'(dValid), 32'd0);
    chk("rst_dout", 32'(dOut), 32'd0);
`endif

    // fill with 0x11..0x88, then drain in order
    wEN = 1;
    for (int i = 1; i <= 8; i++) begin dIn = 8'(i * 8'h11); cyc(); end
    wEN = 0; rEN = 1; rRDY = 1;
    for (int i = 0; i < 8; i++) cyc();
    rEN = 0;

    // full + simultaneous write/read: write dropped, ovf set
    wEN = 1;
    for (int i = 0; i < 8; i++) begin dIn = 8'(8'h20 + i); cyc(); end
    dIn = 8'hEE; rEN = 1; cyc();
    wEN = 0;
    for (int i = 0; i < 7; i++) cyc();
    rEN = 0;

    // underflow, then clear; clear coinciding with an error keeps it set
    rEN = 1; cyc();
    clrErr = 1; cyc();
    rEN = 0; cyc();
    clrErr = 0; cyc();

    // steady write+read at count=3 across pointer wrap
    wEN = 1;
    for (int i = 0; i < 3; i++) begin dIn = 8'(8'h30 + i); cyc(); end
    rEN = 1;
    for (int i = 0; i < 20; i++) begin dIn = 8'($urandom); cyc(); end
    rEN = 0; dIn = 8'h5C; cyc();

    // consumer not ready at count=4: no pop, no underflow
    wEN = 0; rEN = 1; rRDY = 0;
    for (int i = 0; i < 5; i++) cyc();
    rRDY = 1;
    for (int i = 0; i < 4; i++) cyc();
    rEN = 0;

    // asynchronous reset mid-burst at count=5
    wEN = 1;
    for (int i = 0; i < 5; i++) begin dIn = 8'(8'h40 + i); cyc(); end
    #2 RST = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(bEmpty), 32'd1);
    chk("arst_full", 32'(bFull), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("arst_dout", 32'(dOut), 32'd0);
    chk("arst_dvalid", 32'(dValid), 32'd0);
`endif
    #1 RST = 1'b0; wEN = 0;
    sb.delete(); mcount = 0; movf = 0; munf = 0;

    // single word into an empty buffer, then read it back
    wEN = 1; dIn = 8'hA5; cyc();
    wEN = 0; rEN = 1; cyc();
    rEN = 0; cyc();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data word width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries, a power of two, minimum 2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: occupancy at or above which bAlmostFull asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2: occupancy at or below which bAlmostEmpty asserts.
REQ-005 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port wEN, input, 1 bit: write request.
REQ-008 SHALL have port dIn, input, WIDTH bits: write data.
REQ-009 SHALL have port rEN, input, 1 bit: read request.
REQ-010 SHALL have port rRDY, input, 1 bit: downstream consumer ready; gates reads.
REQ-011 SHALL have port dOut, output, WIDTH bits: read data.
REQ-012 SHALL have port dValid, output, 1 bit: dOut carries a freshly popped word.
REQ-013 SHALL have ports bFull and bEmpty, outputs, 1 bit each: buffer full and buffer empty.
REQ-014 SHALL have ports bAlmostFull and bAlmostEmpty, outputs, 1 bit each: threshold flags.
REQ-015 SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-016 SHALL have ports ovf and unf, outputs, 1 bit each: sticky overflow and underflow flags.
REQ-017 SHALL have port clrErr, input, 1 bit: synchronous clear of ovf and unf.

Function
REQ-018 SHALL accept a write when wEN=1 and bFull=0, storing dIn at wPtr and incrementing wPtr.
REQ-019 SHALL accept a read when rEN=1, rRDY=1 and bEmpty=0, incrementing rPtr.
REQ-020 SHALL use pointers of log2(DEPTH)+1 bits with natural modulo-2*DEPTH wrap; there is no explicit wrap compare.
REQ-021 SHALL set bEmpty=1 when wPtr==rPtr, and bFull=1 when the pointer MSBs differ and the lower bits are equal.
REQ-022 SHALL set count = wPtr - rPtr (modulo), bAlmostFull = (count >= AF_LEVEL), and bAlmostEmpty = (count <= AE_LEVEL); all flags are combinational from the pointers.
REQ-023 SHALL treat simultaneous accepted read and write as legal in any non-full, non-empty state, leaving count unchanged.
REQ-024 SHALL reject a write when full, even if a read is accepted in the same cycle; ovf is set on that cycle.
REQ-025 SHALL reject a read when empty, even if a write is accepted in the same cycle; unf is set if rEN=1 and rRDY=1.
REQ-026 SHALL leave a read with rRDY=0 unaccepted, without setting unf and without changing state.
REQ-027 SHALL hold ovf and unf at 1 until clrErr=1 or reset; if clrErr and a new error coincide, the error wins.
REQ-028 SHALL in default mode register dOut from mem[rPtr] on the accepted-read edge (1-cycle latency) and pulse dValid for exactly one cycle; dOut holds its value otherwise.

Reset
REQ-029 SHALL on RST=1 immediately clear wPtr, rPtr, dOut, dValid, ovf and unf, so that bEmpty=1, bFull=0, count=0, bAlmostEmpty=1 and bAlmostFull=0.
REQ-030 SHALL not reset storage contents; a reset mid-operation discards all queued words.

Configuration
REQ-031 SHALL, when macro FIFO_FWFT_EN is defined, provide first-word-fall-through: dOut = mem[rPtr] combinationally, dValid = !bEmpty, and an accepted read pops with zero latency.
REQ-032 SHALL, when FIFO_FWFT_EN is undefined, use the registered 1-cycle read of REQ-028.

Structure
REQ-033 SHALL keep the shared package fifo_pkg holding the clog2-based address-width function and the default DEPTH, AF and AE constants.
REQ-034 SHALL place storage in one sub-module, fifo_mem: a DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port.

Verification (WIDTH=8, DEPTH=8)
REQ-035 SHALL check: reset, write 0x11..0x88 -> count=8, bFull=1, bAlmostFull=1 from count=6; 8 reads return 0x11..0x88 in order, each dValid 1 cycle after its read.
REQ-036 SHALL check: full, wEN=1 and rEN=1 in the same cycle -> the write is dropped, ovf=1, count=7, and the next read still returns the second-oldest word.
REQ-037 SHALL check: empty, rEN=1, rRDY=1 -> unf=1, dValid stays 0; clrErr pulse -> unf=0.
REQ-038 SHALL check: 20 cycles of continuous write plus read at count=3 -> count stays 3, pointers wrap, and data order is preserved.
REQ-039 SHALL check: rEN=1 with rRDY=0 for 5 cycles at count=4 -> no pop; rRDY=1 -> pop resumes.
REQ-040 SHALL check: RST asserted asynchronously mid-burst at count=5 -> count=0, bEmpty=1 and dOut=0 before the next CLK edge; with FIFO_FWFT_EN, writing 0xA5 into an empty buffer -> dOut=0xA5 and dValid=1 on the next cycle.
